// File: rtl/rv32i_mem_responder.sv
// Unified word RAM for the rv32i core with a byte-stream boot loader; optional MMIO via RV32I_MMIO_EN.
// Latency: reads are combinational, writes commit at posedge; backpressure: ld_ready=1 only while loading.
// Every byte presented while loading is accepted; bytes past DEPTH words are dropped and flagged.
module rv32i_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] iaddr,
    output logic [DATA_WIDTH-1:0] idin,
    input  logic [DATA_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] ddout,
    input  logic                  dwe0,
    input  logic                  dwe1,
    input  logic                  dwe2,
    output logic [DATA_WIDTH-1:0] ddin,
    output logic                  core_rst,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ld_overflow,
    output logic                  misalign
`ifdef RV32I_MMIO_EN
    ,
    output logic [DATA_WIDTH-1:0] gpio_out
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem [DEPTH];
    logic [AW:0]     ptr_q;
    logic [1:0]      cnt_q;
    logic [31:0]     buf_q;
    logic            ovf_q, mis_q;
    logic            ld_fire, ld_done, ld_we, run;
    logic [31:0]     ld_word;
    logic [1:0]      off;
    logic            is_sb, is_sh, is_sw, st_mis, mmio_sel;
    logic [3:0]      st_mask, ram_mask;
    logic [31:0]     st_dat, dword;
    logic [63:0]     drot;
    logic            unused_bits;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        core_rst = 1'b0;
        ld_ready = 1'b0;
        case (state_q)
            S_LOAD: begin
                core_rst = 1'b1;
                ld_ready = 1'b1;
                if (ld_valid && ld_last) state_d = S_RUN;
            end
            S_RUN: ;
            default: state_d = S_LOAD;
        endcase
    end

    assign run     = (state_q == S_RUN) && !rst;
    assign ld_fire = ld_valid && (state_q == S_LOAD) && !rst;
    // Incoming byte lands in lane cnt_q; lane 0 is the most significant byte.
    assign ld_word = buf_q | ({ld_data, 24'h0} >> {cnt_q, 3'b000});
    assign ld_done = ld_fire && (ld_last || cnt_q == 2'd3);
    assign ld_we   = ld_done && !ptr_q[AW];

    // ptr saturates at DEPTH, so its top bit alone marks a full RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            buf_q <= '0;
            ovf_q <= 1'b0;
        end else if (ld_fire) begin
            if (ptr_q[AW]) ovf_q <= 1'b1;
            if (ld_done) begin
                buf_q <= '0;
                cnt_q <= '0;
                if (!ptr_q[AW]) ptr_q <= ptr_q + PTR_ONE;
            end else begin
                buf_q <= ld_word;
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    assign off   = daddr[1:0];
    assign is_sb = dwe0 && !dwe1 && !dwe2;
    assign is_sh = dwe0 &&  dwe1 && !dwe2;
    assign is_sw = dwe0 &&  dwe1 &&  dwe2;

    // Mask bit b covers bits [8b+7:8b]; byte offset o is mask bit 3-o.
    always_comb begin
        st_mask = 4'b0000;
        st_mis  = 1'b0;
        if (is_sb) begin
            st_mask = 4'b1000 >> off;
        end else if (is_sh) begin
            if (off[0]) st_mis  = 1'b1;
            else        st_mask = 4'b1100 >> off;
        end else if (is_sw) begin
            if (off != 2'd0) st_mis  = 1'b1;
            else             st_mask = 4'b1111;
        end
    end

    assign st_dat   = ddout >> {off, 3'b000};
    assign ram_mask = (run && !mmio_sel) ? st_mask : 4'b0000;

    always_ff @(posedge clk) begin
        if (ld_we) mem[ptr_q[AW-1:0]] <= ld_word;
        for (int b = 0; b < 4; b++) begin
            if (ram_mask[b]) mem[daddr[AW+1:2]][8*b +: 8] <= st_dat[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                  mis_q <= 1'b0;
        else if (run && st_mis)   mis_q <= 1'b1;
    end

`ifdef RV32I_MMIO_EN
    logic [31:0] gpio_q, cyc_q, mmio_rd;

    assign mmio_sel = daddr[31];

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_q <= '0;
            cyc_q  <= '0;
        end else begin
            if (run) cyc_q <= cyc_q + 32'd1;
            if (run && mmio_sel && is_sw && daddr[30:0] == '0) gpio_q <= ddout;
        end
    end

    always_comb begin
        mmio_rd = '0;
        if (daddr[30:2] == '0)        mmio_rd = gpio_q;
        else if (daddr[30:2] == 29'd1) mmio_rd = cyc_q;
    end

    assign gpio_out = gpio_q;
    assign dword    = mmio_sel ? mmio_rd : mem[daddr[AW+1:2]];
`else
    assign mmio_sel = 1'b0;
    assign dword    = mem[daddr[AW+1:2]];
`endif

    // Left rotation brings the addressed byte/half to the top of ddin.
    assign drot        = {dword, dword} << {off, 3'b000};
    assign ddin        = drot[63:32];
    assign idin        = mem[iaddr[AW+1:2]];
    assign ld_overflow = ovf_q;
    assign misalign    = mis_q;
    assign unused_bits = ^{iaddr[DATA_WIDTH-1:AW+2], iaddr[1:0], daddr[DATA_WIDTH-1:AW+2]};

endmodule

// File: tb/tb_rv32i_mem_responder.sv
// Bench for rv32i_mem_responder: byte-level memory model plus directed literal checks.
module tb_rv32i_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr, daddr, ddout, idin, ddin;
    logic        dwe0, dwe1, dwe2, core_rst, ld_valid, ld_last, ld_ready, ld_overflow, misalign;
    logic [7:0]  ld_data;
    logic        s_rst;
    logic [31:0] s_iaddr, s_idin, s_ddin;
    logic        s_core_rst, s_ld_valid, s_ld_last, s_ld_ready, s_ld_overflow, s_misalign;
    logic [7:0]  s_ld_data;
`ifdef RV32I_MMIO_EN
    logic [31:0] gpio_out, s_gpio_out;
`endif

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    rv32i_mem_responder #(.DATA_WIDTH(32), .DEPTH(1024)) dut (
        .clk(clk), .rst(rst), .iaddr(iaddr), .idin(idin), .daddr(daddr), .ddout(ddout),
        .dwe0(dwe0), .dwe1(dwe1), .dwe2(dwe2), .ddin(ddin), .core_rst(core_rst),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .ld_overflow(ld_overflow), .misalign(misalign)
`ifdef RV32I_MMIO_EN
        , .gpio_out(gpio_out)
`endif
    );

    rv32i_mem_responder #(.DATA_WIDTH(32), .DEPTH(4)) dut_small (
        .clk(clk), .rst(s_rst), .iaddr(s_iaddr), .idin(s_idin), .daddr(32'h0), .ddout(32'h0),
        .dwe0(1'b0), .dwe1(1'b0), .dwe2(1'b0), .ddin(s_ddin), .core_rst(s_core_rst),
        .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(s_ld_last), .ld_ready(s_ld_ready),
        .ld_overflow(s_ld_overflow), .misalign(s_misalign)
`ifdef RV32I_MMIO_EN
        , .gpio_out(s_gpio_out)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // we = {dwe0, dwe1, dwe2}
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] we);
        daddr = a;
        ddout = d;
        {dwe0, dwe1, dwe2} = we;
        step();
        {dwe0, dwe1, dwe2} = 3'b000;
    endtask

    // ---------------- behavioural model: byte-addressed, big-endian words ----------------
    logic [7:0] mb [4096];
    bit         known [1024];
    bit         m_run, m_ovf, m_mis;
    int         m_nbytes;

    function automatic logic [31:0] model_word(input int w);
        return {mb[4*w], mb[4*w+1], mb[4*w+2], mb[4*w+3]};
    endfunction

    function automatic logic [31:0] model_rd(input int w, input int o);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[31-8*j -: 8] = mb[4*w + ((o + j) % 4)];
        return r;
    endfunction

    initial begin
        int w, o, base;
        bit mmio;
        m_run = 0; m_ovf = 0; m_mis = 0; m_nbytes = 0;
        for (int i = 0; i < 1024; i++) known[i] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_run = 0; m_ovf = 0; m_mis = 0; m_nbytes = 0;
            end else if (!m_run) begin
                if (ld_valid) begin
                    if (m_nbytes < 4096) begin
                        mb[m_nbytes] = ld_data;
                        w = m_nbytes / 4;
                        if (ld_last || (m_nbytes % 4) == 3) begin
                            for (int k = m_nbytes % 4 + 1; k < 4; k++) mb[4*w+k] = 8'h00;
                            known[w] = 1;
                        end else begin
                            known[w] = 0;
                        end
                    end else begin
                        m_ovf = 1;
                    end
                    m_nbytes++;
                    if (ld_last) m_run = 1;
                end
            end else begin
                w = int'(daddr[11:2]);
                o = int'(daddr[1:0]);
                base = 4 * w;
                mmio = 1'b0;
`ifdef RV32I_MMIO_EN
                mmio = daddr[31];
`endif
                case ({dwe0, dwe1, dwe2})
                    3'b100: if (!mmio) mb[base+o] = ddout[31:24];
                    3'b110: if (o % 2 != 0) m_mis = 1;
                            else if (!mmio) begin
                                mb[base+o] = ddout[31:24]; mb[base+o+1] = ddout[23:16];
                            end
                    3'b111: if (o != 0) m_mis = 1;
                            else if (!mmio) begin
                                mb[base] = ddout[31:24]; mb[base+1] = ddout[23:16];
                                mb[base+2] = ddout[15:8]; mb[base+3] = ddout[7:0];
                            end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        int w, dw;
        bit mmio;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("core_rst", {31'b0, core_rst}, {31'b0, !m_run});
                chk("ld_ready", {31'b0, ld_ready}, {31'b0, !m_run});
                chk("ld_overflow", {31'b0, ld_overflow}, {31'b0, m_ovf});
                chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
                w  = int'(iaddr[11:2]);
                dw = int'(daddr[11:2]);
                mmio = 1'b0;
`ifdef RV32I_MMIO_EN
                mmio = daddr[31];
`endif
                if (known[w]) chk("idin", idin, model_word(w));
                if (!mmio && known[dw]) chk("ddin", ddin, model_rd(dw, int'(daddr[1:0])));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int acc;
        logic [31:0] e, c1, c2;
        rst = 1'b1; iaddr = '0; daddr = '0; ddout = '0;
        dwe0 = 1'b0; dwe1 = 1'b0; dwe2 = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        s_rst = 1'b1; s_iaddr = '0; s_ld_valid = 1'b0; s_ld_data = '0; s_ld_last = 1'b0;
        step(); step();
        chk("reset core_rst", {31'b0, core_rst}, 32'd1);
        chk("reset ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("reset ld_overflow", {31'b0, ld_overflow}, 32'd0);
        chk("reset misalign", {31'b0, misalign}, 32'd0);
        cmp_en = 1'b1;
        rst = 1'b0;

        send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        ld_valid = 1'b1; ld_data = 8'h93; ld_last = 1'b1;
        #1 chk("core_rst during last", {31'b0, core_rst}, 32'd1);
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("core_rst after last", {31'b0, core_rst}, 32'd0);
        iaddr = 32'h0;
        #1 chk("boot word0", idin, 32'h13000093);

        rst = 1'b1; step(); rst = 1'b0;
        daddr = 32'h4; ddout = 32'hFFFF_FFFF; {dwe0, dwe1, dwe2} = 3'b111;
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
        send(8'hEE, 1'b1);
        {dwe0, dwe1, dwe2} = 3'b000;
        iaddr = 32'h0;
        #1 chk("5B word0", idin, 32'hAABBCCDD);
        iaddr = 32'h4;
        #1 chk("5B word1", idin, 32'hEE000000);
        chk("ld_ready in run", {31'b0, ld_ready}, 32'd0);

        rst = 1'b1; step(); rst = 1'b0;
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        send(8'h05, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        send(8'h77, 1'b1);
        iaddr = 32'h0;
        #1 chk("restart word0", idin, 32'h77000000);
        iaddr = 32'h4;
        #1 chk("restart word1 kept", idin, 32'hEE000000);

        store(32'h10, 32'h11223344, 3'b111);
        store(32'h12, 32'h99000000, 3'b100);
        iaddr = 32'h10; daddr = 32'h12;
        #1 chk("SB word", idin, 32'h11229944);
        chk("LB top byte", ddin >> 24, 32'h99);
        chk("LB rotated", ddin, 32'h99441122);

        store(32'h11, 32'h55660000, 3'b110);
        chk("SH misalign", {31'b0, misalign}, 32'd1);
        #1 chk("SH misaligned no write", idin, 32'h11229944);

        daddr = 32'h10; ddout = 32'hDEADBEEF; {dwe0, dwe1, dwe2} = 3'b111;
        #1 chk("SW same-cycle old", ddin, 32'h11229944);
        step();
        {dwe0, dwe1, dwe2} = 3'b000;
        #1 chk("SW next-cycle new", ddin, 32'hDEADBEEF);

        store(32'h12, 32'hCAFE0000, 3'b110);
        daddr = 32'h12; iaddr = 32'h1010;
        #1 chk("LH rotated", ddin, 32'hCAFEDEAD);
        chk("iaddr wrap", idin, 32'hDEADCAFE);
        store(32'h10, 32'h0, 3'b010);
        iaddr = 32'h10;
        #1 chk("bad dwe no write", idin, 32'hDEADCAFE);
        store(32'h13, 32'hAB000000, 3'b100);
        #1 chk("SB lane3", idin, 32'hDEADCAAB);

`ifdef RV32I_MMIO_EN
        store(32'h8000_0000, 32'h5, 3'b111);
        chk("gpio_out", gpio_out, 32'h5);
        iaddr = 32'h0;
        #1 chk("mmio no ram write", idin, 32'h77000000);
        daddr = 32'h8000_0004;
        #1 c1 = ddin;
        for (int i = 0; i < 7; i++) step();
        c2 = ddin;
        chk("cycle counter delta", c2 - c1, 32'd7);
        daddr = 32'h0;
`endif

        acc = 0;
        s_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_ld_valid = 1'b1;
            s_ld_data  = 8'(i);
            s_ld_last  = (i == 19);
            #1;
            if (s_ld_ready) acc++;
            if (i == 16) chk("small ovf before 17th", {31'b0, s_ld_overflow}, 32'd0);
            step();
        end
        s_ld_valid = 1'b0; s_ld_last = 1'b0;
        chk("small accepted", acc, 32'd20);
        chk("small overflow", {31'b0, s_ld_overflow}, 32'd1);
        chk("small core_rst", {31'b0, s_core_rst}, 32'd0);
        for (int w = 0; w < 4; w++) begin
            s_iaddr = 32'(4 * w);
            e = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
            #1 chk("small mem", s_idin, e);
        end
        s_iaddr = 32'h10;
        #1 chk("small wrap", s_idin, 32'h00010203);

        step();
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
